// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared index-width helper and result type for the priority encoder
package prio_enc_pkg;

  localparam int MAX_W = 8;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // idx is sized for the widest legal N; narrower instances use the low bits only.
  typedef struct packed {
    logic [MAX_W-1:0] idx;
    logic             zero;
    logic             multi;
  } prio_res_t;

endpackage

// File: rtl/prio_enc_core.sv
// rtl/prio_enc_core.sv - combinational scan from a start index downward with wrap
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] d,
  input  logic [W-1:0] start,
  output prio_res_t    res
);

  logic found;

  always_comb begin
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int p;
      p = int'(start) - k;
      if (p < 0) p = p + N;
      if (d[p]) begin
        if (!found) begin
          res.idx = MAX_W'(p);
          found   = 1'b1;
        end else begin
          res.multi = 1'b1;
        end
      end
    end
    res.zero = !found;
  end

endmodule

// File: rtl/priority_encoder_reg.sv
// rtl/priority_encoder_reg.sv - registered priority encoder with valid/ready handshake
// Round-robin scanning is enabled by defining PRIORITY_ENCODER_REG_RR_EN.
module priority_encoder_reg
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_zero,
  output logic         out_multi
);

  prio_res_t    core_res;
  logic [W-1:0] start;
  logic         capture;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         zero_q, zero_d;
  logic         multi_q, multi_d;
  logic         unused_idx_bits;

`ifdef PRIORITY_ENCODER_REG_RR_EN
  logic [W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (capture && !core_res.zero) begin
      rr_ptr_d = (core_res.idx[W-1:0] == '0) ? W'(N - 1) : core_res.idx[W-1:0] - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= W'(N - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign start = rr_ptr_q;
`else
  // Starting at the top index makes the scan plain highest-bit-wins.
  assign start = W'(N - 1);
`endif

  prio_enc_core #(.N(N)) u_core (
    .d     (d),
    .start (start),
    .res   (core_res)
  );

  assign unused_idx_bits = ^core_res.idx;

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    zero_d      = zero_q;
    multi_d     = multi_q;
    if (capture) begin
      out_valid_d = 1'b1;
      idx_d       = core_res.idx[W-1:0];
      zero_d      = core_res.zero;
      multi_d     = core_res.multi;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      zero_q      <= zero_d;
      multi_q     <= multi_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = idx_q;
  assign out_zero  = zero_q;
  assign out_multi = multi_q;

endmodule

// File: tb/tb_priority_encoder_reg.sv
// tb/tb_priority_encoder_reg.sv - self-checking bench for priority_encoder_reg (N=8)
module tb_priority_encoder_reg;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_idx;
  logic         out_zero;
  logic         out_multi;

  int tests  = 0;
  int failed = 0;

  // reference state
  bit m_valid;
  int m_idx;
  bit m_zero;
  bit m_multi;
  int m_ptr;

  always #5 clk = ~clk;

  priority_encoder_reg #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_zero  (out_zero),
    .out_multi (out_multi)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // First set bit scanning down from ptr, wrapping from 0 to N-1.
  function automatic int ref_idx(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (ptr - k + N) % N;
      if (v[p]) return p;
    end
    return 0;
  endfunction

  task automatic model_edge(input bit rst, input bit iv, input bit ordy, input logic [N-1:0] v);
    bit cap;
    if (!rst) begin
      m_valid = 0; m_idx = 0; m_zero = 0; m_multi = 0; m_ptr = N - 1;
      return;
    end
    cap = iv && (!m_valid || ordy);
    if (cap) begin
      m_valid = 1;
      m_idx   = ref_idx(v, m_ptr);
      m_zero  = (v == 0);
      m_multi = ($countones(v) >= 2);
`ifdef PRIORITY_ENCODER_REG_RR_EN
      if (v != 0) m_ptr = (m_idx + N - 1) % N;
`endif
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive inputs, check in_ready, step edge, check registered outputs.
  task automatic cycle(input string tag, input bit rst, input bit iv, input bit ordy,
                       input logic [N-1:0] v);
    rst_n = rst; in_valid = iv; out_ready = ordy; d = v;
    #1;
    if (rst) chk({tag, ".in_ready"}, int'(in_ready), int'(!m_valid || ordy));
    @(posedge clk);
    model_edge(rst, iv, ordy, v);
    #1;
    chk({tag, ".out_valid"}, int'(out_valid), int'(m_valid));
    if (m_valid || !rst) begin
      chk({tag, ".out_idx"},   int'(out_idx),   m_idx);
      chk({tag, ".out_zero"},  int'(out_zero),  int'(m_zero));
      chk({tag, ".out_multi"}, int'(out_multi), int'(m_multi));
    end
  endtask

  initial begin
    logic [N-1:0] v;
    int           held_idx;
    rst_n = 0; in_valid = 0; out_ready = 0; d = '0;
    m_ptr = N - 1;

    // reset
    cycle("reset0", 0, 1, 0, 8'hFF);
    cycle("reset1", 0, 0, 0, 8'h00);
    chk("reset.in_ready", int'(in_ready), 1);
`ifdef PRIORITY_ENCODER_REG_RR_EN
    chk("reset.rr_ptr", int'(dut.rr_ptr_q), N - 1);
`endif

    // one-hot walk
    for (int i = 0; i < N; i++) begin
      v = 8'(1 << i);
      cycle("onehot", 1, 1, 1, v);
      chk("onehot.idx_const", int'(out_idx), i);
    end

    // all-zero and two-bit vectors
    cycle("zero", 1, 1, 1, 8'h00);
    chk("zero.flag_const", int'(out_zero), 1);
    chk("zero.idx_const", int'(out_idx), 0);
    cycle("two_bits", 1, 1, 1, 8'b0110_0000);
    chk("two_bits.multi_const", int'(out_multi), 1);
`ifndef PRIORITY_ENCODER_REG_RR_EN
    chk("two_bits.idx_const", int'(out_idx), 6);
    cycle("msb_lsb", 1, 1, 1, 8'b1000_0001);
    chk("msb_lsb.idx_const", int'(out_idx), 7);
`endif
    cycle("drain", 1, 0, 1, 8'h00);

    // backpressure: hold result for 3 cycles while a second vector waits
    cycle("bp.capture", 1, 1, 0, 8'b0000_1000);
    held_idx = int'(out_idx);
    for (int i = 0; i < 3; i++) begin
      cycle("bp.stall", 1, 1, 0, 8'b0100_0000);
      chk("bp.in_ready_low", int'(in_ready), 0);
      chk("bp.idx_held", int'(out_idx), held_idx);
    end
    cycle("bp.release", 1, 1, 1, 8'b0100_0000);
    chk("bp.second_idx", int'(out_idx), 6);
    cycle("bp.drain", 1, 0, 1, 8'h00);

    // streaming, no bubbles
    for (int i = 0; i < 16; i++) begin
      cycle("stream", 1, 1, 1, 8'($urandom));
      chk("stream.valid_const", int'(out_valid), 1);
    end

`ifdef PRIORITY_ENCODER_REG_RR_EN
    for (int i = 0; i < 6; i++) begin
      cycle("rr", 1, 1, 1, 8'b1000_0001);
    end
`endif

    // random handshake traffic
    for (int i = 0; i < 60; i++) begin
      cycle("random", 1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 8'($urandom));
    end

    // reset during a stall with a capture attempt
    cycle("rst_stall.capture", 1, 1, 0, 8'b0001_0010);
    cycle("rst_stall.hold", 1, 1, 0, 8'b0001_0010);
    chk("rst_stall.valid_before", int'(out_valid), 1);
    cycle("rst_stall.reset", 0, 1, 0, 8'hA5);
    chk("rst_stall.valid_const", int'(out_valid), 0);
    chk("rst_stall.in_ready", int'(in_ready), 1);
`ifdef PRIORITY_ENCODER_REG_RR_EN
    chk("rst_stall.rr_ptr", int'(dut.rr_ptr_q), 7);
`endif
    cycle("post_reset", 1, 1, 1, 8'b0000_0100);
    chk("post_reset.idx_const", int'(out_idx), 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/priority_encoder_reg.md
PRIORITY_ENCODER_REG -- requirements
Module: priority_encoder_reg

Interface
REQ-001 SHALL have parameter N, default 8: request vector width, legal range 2..256.
REQ-002 SHALL have localparam W, default $clog2(N): index width, derived from N and not overridable.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: d is presented.
REQ-006 SHALL have port in_ready, output, 1: block accepts d this cycle.
REQ-007 SHALL have port d, input, N: request bits, where bit i means index i.
REQ-008 SHALL have port out_valid, output, 1: result register holds a result.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port out_idx, output, W: encoded index of the winning bit.
REQ-011 SHALL have port out_zero, output, 1: the captured d had no bit set.
REQ-012 SHALL have port out_multi, output, 1: the captured d had two or more bits set.

Function
REQ-013 SHALL capture on (in_valid && in_ready); results are registered, so out_valid rises 1 cycle after capture.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (combinational; single output register, no skid buffer).
REQ-015 SHALL hold out_idx, out_zero and out_multi stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid after (out_valid && out_ready) when no new capture occurs in the same cycle.
REQ-017 SHALL, on simultaneous accept and capture, load the new result and keep out_valid at 1 (full throughput, one result per cycle).
REQ-018 SHALL, in fixed-priority mode, make the highest set index win: d = 8'b1000_0001 gives out_idx = 7.
REQ-019 SHALL, for one-hot d, set out_idx to the bit position (8-to-3 truth table: d[5] only gives 3'd5).
REQ-020 SHALL, for d == 0, set out_zero = 1, out_idx = 0 and out_multi = 0.
REQ-021 SHALL ignore d whenever in_valid is 0; no state change.
REQ-022 SHALL make out_idx always less than N; for non-power-of-two N, unused codes are never produced.

Reset
REQ-023 SHALL, at a clk edge with rst_n = 0, set out_valid = 0, out_idx = 0, out_zero = 0, out_multi = 0 and rr_ptr = N-1.
REQ-024 SHALL drive in_ready = 1 during and after reset, since out_valid = 0.
REQ-025 SHALL let reset override a simultaneous capture; a pending result is discarded without handshake.

Configuration
REQ-026 SHALL, with macro PRIORITY_ENCODER_REG_RR_EN defined, add a rotating W-bit pointer rr_ptr.
REQ-027 SHALL, in RR mode, scan downward from rr_ptr with wrap from 0 to N-1; the first set bit wins.
REQ-028 SHALL, in RR mode, update rr_ptr to (out_idx - 1) mod N on each capture with nonzero d; rr_ptr is unchanged for d == 0 or when there is no capture.
REQ-029 SHALL, without the macro, use fixed priority only (REQ-018); no rr_ptr register exists.

Structure
REQ-030 SHALL define in a shared package prio_enc_pkg: a function for the index-width computation and the result struct {idx, zero, multi} typedef, parameterised through the module.
REQ-031 SHALL use one combinational sub-module, prio_enc_core (N, start pointer input, returns result struct), which is reused for both modes.

Verification
REQ-032 SHALL check, for N=8 fixed mode, each one-hot d in turn: out_idx = 0..7 one cycle later, out_zero = 0, out_multi = 0.
REQ-033 SHALL check d = 8'b0000_0000 -> out_zero = 1, out_idx = 0; and d = 8'b0110_0000 -> out_idx = 6, out_multi = 1.
REQ-034 SHALL check backpressure: out_ready = 0 for 3 cycles after capture gives in_ready = 0 and stable outputs; the second vector is accepted the cycle out_ready = 1.
REQ-035 SHALL check streaming: in_valid = out_ready = 1 for 16 cycles gives 16 results in order with no bubbles.
REQ-036 SHALL check RR mode with PRIORITY_ENCODER_REG_RR_EN: d = 8'b1000_0001 repeated gives out_idx = 7, 0, 7, 0...
REQ-037 SHALL check reset mid-stall (out_valid = 1, out_ready = 0, rst_n = 0): next cycle out_valid = 0, in_ready = 1 and rr_ptr = 7.
